// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader_pkg
// Description : Constants and FSM state encoding shared by the instruction
//               loader and its packer.
//               Contents: HALT_OPCODE, OPCODE_W, loader_state_t.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_loader_pkg;

  // Opcode field width; it sits in the top bits of every instruction word.
  localparam int OPCODE_W = 6;

  // An instruction word whose opcode equals this terminates a program load.
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader_if
// Description : Byte-stream in / instruction-memory-write out bundle of the
//               instruction loader.
//               i_start, i_rx_data, i_rx_valid         : load control + bytes
//               o_mem_write, o_mem_addr, o_mem_data    : memory write port
//               o_loading, o_done, o_overflow,
//               o_word_count                           : status
//               slave  : the loader
//               master : whatever feeds the loader and consumes its writes
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_loader_if #(
  parameter int NB      = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 8
);

  logic               i_start;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_mem_write;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB-1:0]      o_mem_data;
  logic               o_loading;
  logic               o_done;
  logic               o_overflow;
  logic [NB_ADDR:0]   o_word_count;

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_mem_write, o_mem_addr, o_mem_data,
    output o_loading, o_done, o_overflow, o_word_count
  );

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_mem_write, o_mem_addr, o_mem_data,
    input  o_loading, o_done, o_overflow, o_word_count
  );

endinterface
`default_nettype wire

// File: rtl/instruction_loader_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_to_word_packer
// Description : Shifts bytes into a word, most significant byte first.
//               o_word is the word completed by the byte currently offered,
//               o_word_valid pulses (combinationally) when that byte is the
//               last of a word, so the caller can register it with no extra
//               latency.
//               i_clk, i_reset      : clock, async active-high reset
//               i_clear             : drop any partial word (wins over bytes)
//               i_byte_valid/i_byte : byte to accept this cycle
//               o_word/o_word_valid : assembled word and completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module byte_to_word_packer #(
  parameter int NB      = 32,
  parameter int NB_BYTE = 8
) (
  input  wire logic               i_clk,
  input  wire logic               i_reset,
  input  wire logic               i_clear,
  input  wire logic               i_byte_valid,
  input  wire logic [NB_BYTE-1:0] i_byte,
  output      logic [NB-1:0]      o_word,
  output      logic               o_word_valid
);

  localparam int BYTES = NB / NB_BYTE;
  localparam int CW    = $clog2(BYTES);

  logic [NB-1:0] r_shift;
  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last       = (r_count == CW'(BYTES - 1));
  assign o_word       = {r_shift[NB-NB_BYTE-1:0], i_byte};
  assign o_word_valid = i_byte_valid && w_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_byte_valid) begin
      r_shift <= o_word;
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Loads a program received as a byte stream into instruction
//               memory. i_start opens a load; every four bytes form one
//               big-endian word that is written at the next word address.
//               The load ends on a HALT word or when the last address has
//               been written (overflow).
//               i_clk, i_reset : clock, async active-high reset
//               bus (slave)    : control/byte inputs, memory write, status
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int NB      = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 8
) (
  input wire logic               i_clk,
  input wire logic               i_reset,
  instruction_loader_if.slave    bus
);

  loader_state_t      r_state;
  loader_state_t      w_state_next;
  logic               r_mem_write;
  logic [NB_ADDR-1:0] r_mem_addr;
  logic [NB-1:0]      r_mem_data;
  logic               r_overflow;
  logic [NB_ADDR:0]   r_word_count;

  logic               w_byte_accept;
  logic [NB-1:0]      w_word;
  logic               w_word_valid;
  logic               w_is_halt;
  logic               w_addr_last;

  // i_start has priority: a coincident byte is dropped.
  assign w_byte_accept = (r_state == ST_LOAD) && !bus.i_start && bus.i_rx_valid;

  byte_to_word_packer #(
    .NB      (NB),
    .NB_BYTE (NB_BYTE)
  ) u_packer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (bus.i_start),
    .i_byte_valid (w_byte_accept),
    .i_byte       (bus.i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // End-of-load decisions look at the word being written this cycle.
  assign w_is_halt   = (r_mem_data[NB-1 -: OPCODE_W] == HALT_OPCODE);
  assign w_addr_last = (r_mem_addr == {NB_ADDR{1'b1}});

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.i_start) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (r_mem_write && (w_is_halt || w_addr_last)) w_state_next = ST_DONE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else if (bus.i_start) begin
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_mem_write <= w_word_valid;
      if (w_word_valid) r_mem_data <= w_word;
      // Address/count advance in the cycle after the strobe; the address
      // saturates at the top instead of wrapping.
      if (r_mem_write) begin
        r_word_count <= r_word_count + (NB_ADDR + 1)'(1);
        if (!w_addr_last) r_mem_addr <= r_mem_addr + NB_ADDR'(1);
        if (w_addr_last && !w_is_halt) r_overflow <= 1'b1;
      end
    end
  end

  assign bus.o_mem_write  = r_mem_write;
  assign bus.o_mem_addr   = r_mem_addr;
  assign bus.o_mem_data   = r_mem_data;
  assign bus.o_loading    = (r_state == ST_LOAD);
  assign bus.o_done       = (r_state == ST_DONE);
  assign bus.o_overflow   = r_overflow;
  assign bus.o_word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Self-checking bench for instruction_loader. Two DUTs: the
//               default geometry (256 words) and a 4-word memory for the
//               overflow / HALT-at-last-address cases. Expected writes are
//               queued by the stimulus; per-DUT monitors pop them whenever a
//               write strobe is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  logic [39:0] q  [$];  // {addr[7:0], data[31:0]} for the 256-word DUT
  logic [33:0] q2 [$];  // {addr[1:0], data[31:0]} for the 4-word DUT

  instruction_loader_if #(.NB(32), .NB_BYTE(8), .NB_ADDR(8)) b ();
  instruction_loader_if #(.NB(32), .NB_BYTE(8), .NB_ADDR(2)) b2 ();

  instruction_loader #(.NB(32), .NB_BYTE(8), .NB_ADDR(8)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (b)
  );

  instruction_loader #(.NB(32), .NB_BYTE(8), .NB_ADDR(2)) u_dut2 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitors: one compare per observed strobe cycle.
  always @(negedge clk) begin
    if (b.o_mem_write === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got addr=%0h data=%08h, required no write",
                 b.o_mem_addr, b.o_mem_data);
      end else begin
        check("wr", {24'd0, b.o_mem_addr, b.o_mem_data}, {24'd0, q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (b2.o_mem_write === 1'b1) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr2_unexpected: got addr=%0h data=%08h, required no write",
                 b2.o_mem_addr, b2.o_mem_data);
      end else begin
        check("wr2", {30'd0, b2.o_mem_addr, b2.o_mem_data}, {30'd0, q2.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) b2.i_start = 1'b1;
    else     b.i_start  = 1'b1;
    tick(1);
    b.i_start  = 1'b0;
    b2.i_start = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] d);
    if (sel) begin
      b2.i_rx_valid = 1'b1;
      b2.i_rx_data  = d;
    end else begin
      b.i_rx_valid = 1'b1;
      b.i_rx_data  = d;
    end
    tick(1);
    b.i_rx_valid  = 1'b0;
    b2.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) send_byte(sel, t[i*8 +: 8]);
  endtask

  initial begin
    rst = 1'b1;
    b.i_start = 1'b0;  b.i_rx_valid = 1'b0;  b.i_rx_data = 8'h00;
    b2.i_start = 1'b0; b2.i_rx_valid = 1'b0; b2.i_rx_data = 8'h00;
    tick(2);

    // Reset state
    check("rst_write",   b.o_mem_write,  0);
    check("rst_addr",    b.o_mem_addr,   0);
    check("rst_data",    b.o_mem_data,   0);
    check("rst_loading", b.o_loading,    0);
    check("rst_done",    b.o_done,       0);
    check("rst_ovf",     b.o_overflow,   0);
    check("rst_count",   b.o_word_count, 0);
    rst = 1'b0;
    tick(3);

    // IDLE ignores bytes: stays idle, nothing written
    check("idle_loading", b.o_loading, 0);
    send_word(0, 32'h11223344);
    tick(2);
    check("idle_count", b.o_word_count, 0);
    check("idle_loading2", b.o_loading, 0);

    // Single word
    pulse_start(0);
    check("start_loading", b.o_loading, 1);
    q.push_back({8'd0, 32'h20080005});
    send_word(0, 32'h20080005);
    tick(1);
    check("w1_count",   b.o_word_count, 1);
    check("w1_loading", b.o_loading,    1);
    check("w1_addr",    b.o_mem_addr,   1);

    // Back-to-back bytes across a word boundary
    pulse_start(0);
    q.push_back({8'd0, 32'h01020304});
    q.push_back({8'd1, 32'h05060708});
    for (int i = 1; i <= 8; i++) send_byte(0, 8'(i));
    tick(1);
    check("b2b_count", b.o_word_count, 2);

    // HALT ends the load
    pulse_start(0);
    q.push_back({8'd0, 32'h00000020});
    q.push_back({8'd1, 32'hFC000000});
    send_word(0, 32'h00000020);
    send_word(0, 32'hFC000000);
    tick(1);
    check("halt_done",    b.o_done,       1);
    check("halt_loading", b.o_loading,    0);
    check("halt_count",   b.o_word_count, 2);
    check("halt_ovf",     b.o_overflow,   0);
    send_word(0, 32'h55667788);   // ignored in DONE
    tick(2);
    check("done_count", b.o_word_count, 2);

    // Partial word discarded by restart; start+byte coincidence drops byte
    pulse_start(0);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    b.i_rx_valid = 1'b1;
    b.i_rx_data  = 8'h99;
    pulse_start(0);
    q.push_back({8'd0, 32'hAABBCCDD});
    send_word(0, 32'hAABBCCDD);
    tick(1);
    check("restart_count", b.o_word_count, 1);

    // Reset just after the fourth byte: no strobe, everything cleared
    pulse_start(0);
    send_byte(0, 8'h01);
    send_byte(0, 8'h02);
    send_byte(0, 8'h03);
    b.i_rx_valid = 1'b1;
    b.i_rx_data  = 8'h04;
    @(posedge clk);
    #1;
    rst = 1'b1;
    b.i_rx_valid = 1'b0;
    @(negedge clk);
    check("ar_write",   b.o_mem_write,  0);
    check("ar_addr",    b.o_mem_addr,   0);
    check("ar_data",    b.o_mem_data,   0);
    check("ar_loading", b.o_loading,    0);
    check("ar_done",    b.o_done,       0);
    check("ar_ovf",     b.o_overflow,   0);
    check("ar_count",   b.o_word_count, 0);
    tick(1);
    rst = 1'b0;
    tick(3);
    check("ar_idle_loading", b.o_loading, 0);
    check("ar_idle_done",    b.o_done,    0);

    // 4-word memory: fill without HALT -> overflow
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      q2.push_back({2'(i), 32'(i + 1) * 32'h01000001});
      send_word(1, 32'(i + 1) * 32'h01000001);
    end
    tick(1);
    check("ovf_done",    b2.o_done,       1);
    check("ovf_flag",    b2.o_overflow,   1);
    check("ovf_count",   b2.o_word_count, 4);
    check("ovf_loading", b2.o_loading,    0);
    tick(2);
    check("ovf_addr", b2.o_mem_addr, 3);

    // Restart clears overflow; HALT at the last address is not an overflow
    pulse_start(1);
    check("ovf_clr",   b2.o_overflow,   0);
    check("ovf_addr0", b2.o_mem_addr,   0);
    check("ovf_cnt0",  b2.o_word_count, 0);
    for (int i = 0; i < 3; i++) begin
      q2.push_back({2'(i), 32'h00000100 + 32'(i)});
      send_word(1, 32'h00000100 + 32'(i));
    end
    q2.push_back({2'd3, 32'hFC000001});
    send_word(1, 32'hFC000001);
    tick(1);
    check("lasthalt_done",  b2.o_done,       1);
    check("lasthalt_ovf",   b2.o_overflow,   0);
    check("lasthalt_count", b2.o_word_count, 4);

    tick(3);
    check("q_empty",  q.size(),  0);
    check("q2_empty", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
